sys_uptime_counter: RTL and testbench
=====================================

Name: sys_uptime_counter

Overview:
- Downstream consumer of the periodic system-timer tick.
- Counts tick events through a programmable prescaler into a 32-bit uptime counter.
- Provides a one-shot/re-armable compare alarm with interrupt.
- Exposes all state over a 16-bit Avalon-MM slave, alongside the timer on the system bus.

Parameters:
- PRESCALE_W, 16, width of prescale register and prescale counter (≤16).
- PRESCALE_RESET, 0, reset value of prescale register (0 = increment on every tick).
- COUNT_RESET, 32'h0, reset value of the uptime count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_in  in  1  timer tick (level or pulse; rising edge counts)
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  alarm interrupt

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - readdata=0, irq=0
  - count=COUNT_RESET, prescale=PRESCALE_RESET, prescale_cnt=0
  - control=0, alarm=0, shadow=0
  - flags overflow and alarm_flag = 0
  - alarm FSM=IDLE, tick_d=0
- Register map (16-bit):
  - 0 status: rd {13'b0, overflow, run, alarm_flag}; any write clears alarm_flag and overflow.
  - 1 control: rd/wr bits[2:0] = {auto_rearm, irq_en, run}.
  - 2 count_lo: rd count[15:0] and same cycle latches count[31:16] into shadow; any write clears count and prescale_cnt to 0.
  - 3 count_hi: rd shadow; writes ignored.
  - 4 alarm_lo: rd/wr alarm[15:0].
  - 5 alarm_hi: rd/wr alarm[31:16]; write also arms the alarm (FSM to ARMED, alarm_flag cleared).
  - 6 prescale: rd/wr prescale[PRESCALE_W-1:0], zero-extended; write also zeroes prescale_cnt.
  - 7 reserved: rd 0, writes ignored.
- Read latency: readdata is registered, valid the cycle after chipselect with address; it holds its value otherwise.
- Tick detect:
  - tick_d <= tick_in every cycle.
  - tick_edge = tick_in & ~tick_d.
  - A level held high counts once.
- Counting, only when run=1 and tick_edge:
  - If prescale_cnt==prescale: prescale_cnt<=0, count<=count+1.
  - Else prescale_cnt<=prescale_cnt+1.
  - The run=0 clear does not reset prescale_cnt; it freezes.
- Wrap: count 32'hFFFF_FFFF+1 -> 0 and sets sticky overflow.
- Alarm FSM:
  - IDLE: no compare. Entered on reset and on status write with auto_rearm=0.
  - ARMED: when count==alarm (registered values) -> FIRED, alarm_flag<=1. The flag is visible one cycle after count reaches alarm.
  - FIRED: holds.
    - Status write -> IDLE if auto_rearm=0, ARMED if auto_rearm=1 (fires again at next wrap-around match).
    - alarm_hi write -> ARMED.
- irq = alarm_flag & irq_en, registered-flag derived; no combinational path from bus inputs.
- Simultaneous events:
  - count_lo write and increment in the same cycle: write wins, count=0.
  - Status write and match in the same cycle: clear wins, FSM leaves FIRED/ARMED per the rule above, and the match is lost.
  - Status write and wrap in the same cycle: overflow ends at 1 (set wins over clear).
  - alarm_hi write while the match condition holds: FSM=ARMED, then fires on the following cycle if still equal.
- Prescale write smaller than the current prescale_cnt is safe, because prescale_cnt is zeroed on write.
- Reset mid-operation returns everything to reset values next edge; irq drops the same edge.

Test Plan:
- Reset, run=1, prescale=0, 5 single-cycle tick pulses -> count_lo reads 5, count_hi 0; tick_in held high 20 cycles counts 1.
- prescale=3, run=1, 12 tick edges -> count=3; run=0 then 4 edges -> count unchanged.
- Write count_lo(any) then tick so count reaches 32'h0001_0000; read addr2 then addr3 -> 16'h0000, 16'h0001; count advancing between the two reads does not change shadow.
- alarm=7, irq_en=1, run=1, ticks -> irq rises one cycle after count==7; status write drops irq, FSM IDLE; count reaching 7 again after wrap gives no irq.
- auto_rearm=1, alarm=2: fire, status clear -> FSM ARMED; force count near 32'hFFFF_FFFF via ticks from a COUNT_RESET=32'hFFFF_FFFE build -> wrap sets overflow, irq re-fires at count 2.
- Assert reset while FIRED with irq=1 -> next edge irq=0, readdata=0, all registers at reset values.

Source files
------------

// File: rtl/sys_uptime_counter.sv
// rtl/sys_uptime_counter.sv - tick-driven 32-bit uptime counter with prescaler, compare alarm and 16-bit slave
// Bus-visible state is registered; irq comes only from registered flags.
module sys_uptime_counter #(
  parameter int                    PRESCALE_W     = 16,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RESET = '0,
  parameter logic [31:0]           COUNT_RESET    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED} alarm_state_e;

  logic [31:0]           count_q, count_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [2:0]            control_q, control_d;
  logic [31:0]           alarm_q, alarm_d;
  logic [15:0]           shadow_q, shadow_d;
  logic                  overflow_q, overflow_d;
  logic                  flag_q, flag_d;
  alarm_state_e          state_q, state_d;
  logic                  tick_q;
  logic [15:0]           rdata_q, rdata_d;

  logic                  wr, rd, tick_edge, wrap;
  logic                  wr_status, wr_control, wr_count_lo, wr_alarm_lo, wr_alarm_hi, wr_prescale;
  logic [15:0]           prescale_ext;

  always_comb begin
    prescale_ext                 = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale_q;
  end

  assign wr          = chipselect & ~write_n;
  assign rd          = chipselect & write_n;
  assign wr_status   = wr && (address == 3'd0);
  assign wr_control  = wr && (address == 3'd1);
  assign wr_count_lo = wr && (address == 3'd2);
  assign wr_alarm_lo = wr && (address == 3'd4);
  assign wr_alarm_hi = wr && (address == 3'd5);
  assign wr_prescale = wr && (address == 3'd6);
  assign tick_edge   = tick_in & ~tick_q;

  always_comb begin
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    control_d  = control_q;
    alarm_d    = alarm_q;
    shadow_d   = shadow_q;
    overflow_d = overflow_q;
    flag_d     = flag_q;
    state_d    = state_q;
    rdata_d    = rdata_q;
    wrap       = 1'b0;

    if (control_q[0] && tick_edge) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = '0;
        count_d = count_q + 32'd1;
        wrap    = (count_q == 32'hFFFF_FFFF);
      end else begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
    end

    if (state_q == ST_ARMED && count_q == alarm_q) begin
      state_d = ST_FIRED;
      flag_d  = 1'b1;
    end

    // Bus writes come after the counter/FSM updates so they take priority.
    if (wr_status) begin
      overflow_d = 1'b0;
      flag_d     = 1'b0;
      state_d    = control_q[2] ? ST_ARMED : ST_IDLE;
    end
    if (wrap && !wr_count_lo) overflow_d = 1'b1;
    if (wr_control)  control_d = writedata[2:0];
    if (wr_count_lo) begin
      count_d = '0;
      pcnt_d  = '0;
    end
    if (wr_alarm_lo) alarm_d[15:0] = writedata;
    if (wr_alarm_hi) begin
      alarm_d[31:16] = writedata;
      state_d        = ST_ARMED;
      flag_d         = 1'b0;
    end
    if (wr_prescale) begin
      prescale_d = writedata[PRESCALE_W-1:0];
      pcnt_d     = '0;
    end

    if (rd) begin
      case (address)
        3'd0: rdata_d = {13'b0, overflow_q, control_q[0], flag_q};
        3'd1: rdata_d = {13'b0, control_q};
        3'd2: begin
          rdata_d  = count_q[15:0];
          shadow_d = count_q[31:16];
        end
        3'd3: rdata_d = shadow_q;
        3'd4: rdata_d = alarm_q[15:0];
        3'd5: rdata_d = alarm_q[31:16];
        3'd6: rdata_d = prescale_ext;
        default: rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= COUNT_RESET;
      prescale_q <= PRESCALE_RESET;
      pcnt_q     <= '0;
      control_q  <= '0;
      alarm_q    <= '0;
      shadow_q   <= '0;
      overflow_q <= 1'b0;
      flag_q     <= 1'b0;
      state_q    <= ST_IDLE;
      tick_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      control_q  <= control_d;
      alarm_q    <= alarm_d;
      shadow_q   <= shadow_d;
      overflow_q <= overflow_d;
      flag_q     <= flag_d;
      state_q    <= state_d;
      tick_q     <= tick_in;
      rdata_q    <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = flag_q & control_q[1];

endmodule

// File: tb/tb_sys_uptime_counter.sv
// tb/tb_sys_uptime_counter.sv - directed scoreboard bench for sys_uptime_counter
// Three builds: default, count near a 16-bit carry, and count near 32-bit wrap.
module tb_sys_uptime_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  tick, cs, wn;
  logic [2:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic [2:0]  irq;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  sys_uptime_counter dut0 (
    .clk(clk), .reset(reset), .tick_in(tick[0]), .address(addr[0]), .chipselect(cs[0]),
    .write_n(wn[0]), .writedata(wdata[0]), .readdata(rdata[0]), .irq(irq[0]));

  sys_uptime_counter #(.COUNT_RESET(32'h0000_FFFF)) dut1 (
    .clk(clk), .reset(reset), .tick_in(tick[1]), .address(addr[1]), .chipselect(cs[1]),
    .write_n(wn[1]), .writedata(wdata[1]), .readdata(rdata[1]), .irq(irq[1]));

  sys_uptime_counter #(.COUNT_RESET(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .reset(reset), .tick_in(tick[2]), .address(addr[2]), .chipselect(cs[2]),
    .write_n(wn[2]), .writedata(wdata[2]), .readdata(rdata[2]), .irq(irq[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int s, input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cs[s] = 1'b1; wn[s] = 1'b0; addr[s] = a; wdata[s] = d;
    @(posedge clk); #1;
    cs[s] = 1'b0; wn[s] = 1'b1;
  endtask

  task automatic bus_read(input int s, input logic [2:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string       t;
    @(posedge clk); #1;
    cs[s] = 1'b1; wn[s] = 1'b1; addr[s] = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    cs[s] = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {16'h0, rdata[s]}, {16'h0, e});
  endtask

  task automatic pulse(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick[s] = 1'b1;
      @(posedge clk); #1 tick[s] = 1'b0;
    end
  endtask

  initial begin
    tick = '0; cs = '0; wn = '1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdata[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", {16'h0, rdata[0]}, 32'h0);
    chk("rst_irq", {31'h0, irq[0]}, 32'h0);
    reset = 1'b0;

    // Basic counting, prescale 0
    bus_read(0, 3'd0, 16'h0000, "status_rst");
    bus_read(0, 3'd2, 16'h0000, "count_lo_rst");
    bus_write(0, 3'd1, 16'h0001);
    pulse(0, 5);
    bus_read(0, 3'd2, 16'h0005, "count_lo_5");
    bus_read(0, 3'd3, 16'h0000, "count_hi_5");
    repeat (4) @(posedge clk);
    #1 chk("rdata_hold", {16'h0, rdata[0]}, 32'h0);
    @(posedge clk); #1 tick[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1 tick[0] = 1'b0;
    bus_read(0, 3'd2, 16'h0006, "count_lo_level");

    // Prescale 3 and run freeze
    bus_write(0, 3'd6, 16'h0003);
    bus_write(0, 3'd2, 16'h1234);
    pulse(0, 12);
    bus_read(0, 3'd2, 16'h0003, "count_lo_ps3");
    bus_read(0, 3'd6, 16'h0003, "prescale_rd");
    bus_write(0, 3'd1, 16'h0000);
    pulse(0, 4);
    bus_read(0, 3'd2, 16'h0003, "count_lo_frozen");
    bus_read(0, 3'd0, 16'h0000, "status_stopped");
    bus_write(0, 3'd7, 16'hFFFF);
    bus_read(0, 3'd7, 16'h0000, "reserved_rd");

    // One-shot alarm at 7
    bus_write(0, 3'd6, 16'h0000);
    bus_write(0, 3'd2, 16'h0000);
    bus_write(0, 3'd4, 16'h0007);
    bus_write(0, 3'd5, 16'h0000);
    bus_read(0, 3'd4, 16'h0007, "alarm_lo_rd");
    bus_read(0, 3'd5, 16'h0000, "alarm_hi_rd");
    bus_write(0, 3'd1, 16'h0003);
    pulse(0, 6);
    chk("irq_before", {31'h0, irq[0]}, 32'h0);
    pulse(0, 1);
    chk("irq_at_match", {31'h0, irq[0]}, 32'h0);
    @(posedge clk); #1;
    chk("irq_fired", {31'h0, irq[0]}, 32'h1);
    bus_read(0, 3'd0, 16'h0003, "status_fired");
    bus_read(0, 3'd1, 16'h0003, "control_rd");
    bus_write(0, 3'd0, 16'h0000);
    chk("irq_cleared", {31'h0, irq[0]}, 32'h0);
    bus_read(0, 3'd0, 16'h0002, "status_cleared");
    bus_write(0, 3'd2, 16'h0000);
    pulse(0, 7);
    repeat (3) @(posedge clk);
    #1 chk("irq_idle_nofire", {31'h0, irq[0]}, 32'h0);
    bus_read(0, 3'd0, 16'h0002, "status_idle");

    // Shadow latching across a 16-bit carry
    bus_write(1, 3'd1, 16'h0001);
    pulse(1, 1);
    bus_read(1, 3'd2, 16'h0000, "carry_lo");
    bus_read(1, 3'd3, 16'h0001, "carry_hi");
    bus_write(1, 3'd3, 16'hABCD);
    bus_read(1, 3'd3, 16'h0001, "hi_write_ignored");
    bus_write(1, 3'd2, 16'h0000);
    pulse(1, 1);
    bus_read(1, 3'd3, 16'h0001, "shadow_stable");
    bus_read(1, 3'd2, 16'h0001, "lo_after_clear");
    bus_read(1, 3'd3, 16'h0000, "shadow_relatched");

    // Wrap, overflow and auto re-arm
    bus_write(2, 3'd4, 16'h0002);
    bus_write(2, 3'd5, 16'h0000);
    bus_write(2, 3'd1, 16'h0007);
    pulse(2, 2);
    bus_read(2, 3'd0, 16'h0006, "status_wrapped");
    chk("irq_wrap", {31'h0, irq[2]}, 32'h0);
    pulse(2, 2);
    chk("irq2_at_match", {31'h0, irq[2]}, 32'h0);
    @(posedge clk); #1;
    chk("irq2_fired", {31'h0, irq[2]}, 32'h1);
    bus_read(2, 3'd0, 16'h0007, "status2_fired");
    pulse(2, 1);
    bus_write(2, 3'd0, 16'h0000);
    chk("irq2_cleared", {31'h0, irq[2]}, 32'h0);
    bus_read(2, 3'd0, 16'h0002, "status2_cleared");
    bus_write(2, 3'd2, 16'h0000);
    pulse(2, 2);
    @(posedge clk); #1;
    chk("irq2_refired", {31'h0, irq[2]}, 32'h1);
    bus_read(2, 3'd0, 16'h0003, "status2_refired");

    // Reset while fired
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2_irq", {31'h0, irq[2]}, 32'h0);
    chk("rst2_rdata", {16'h0, rdata[2]}, 32'h0);
    reset = 1'b0;
    bus_read(2, 3'd2, 16'hFFFE, "rst2_count_lo");
    bus_read(2, 3'd3, 16'hFFFF, "rst2_count_hi");
    bus_read(2, 3'd0, 16'h0000, "rst2_status");
    bus_read(2, 3'd1, 16'h0000, "rst2_control");
    bus_read(2, 3'd4, 16'h0000, "rst2_alarm_lo");
    bus_read(2, 3'd5, 16'h0000, "rst2_alarm_hi");
    bus_read(2, 3'd6, 16'h0000, "rst2_prescale");
    pulse(2, 2);
    bus_read(2, 3'd2, 16'hFFFE, "rst2_stopped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
